sorted_vector_serializer: RTL

- Downstream consumer of the bitonic sorter's flattened sorted output.
- Captures one sorted NUM_WAY-element vector per handshake.
- Emits the elements one per cycle in ascending way order (way 0 first) on a valid/ready stream, with last and index sidebands.
- Lets narrow downstream logic (merge/top-K, writeback) consume sorter results without a full-width datapath.

---
 rtl/sorted_vector_serializer.sv | 88 ++++++++
 1 files changed

// File: rtl/sorted_vector_serializer.sv
// sorted_vector_serializer: captures one sorted vector and streams its elements way 0 first.
// Define SORTED_VECTOR_SERIALIZER_DEDUP_EN to skip ways equal to their lower neighbour.
module sorted_vector_serializer #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY = 16,
  parameter int INDEX_WIDTH = $clog2(NUM_WAY)
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic                                  flush_in,
  input  logic                                  sorted_valid_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] sorted_flatted_in,
  output logic                                  sorted_ready_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]   element_out,
  output logic [INDEX_WIDTH-1:0]                element_index_out,
  output logic                                  element_last_out,
  output logic                                  element_valid_out,
  input  logic                                  element_ready_in
);
  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d, next_index;
  logic [W-1:0] vec_q [NUM_WAY];
  logic [W-1:0] vec_d [NUM_WAY];
  logic stream, last, capture, emit;
`ifdef SORTED_VECTOR_SERIALIZER_DEDUP_EN
  logic [NUM_WAY-1:0] mask_q, mask_d;
  // descending scan leaves the lowest clear mask bit above index_q in next_index
  always_comb begin
    last = 1'b1;
    next_index = index_q;
    for (int i = NUM_WAY - 1; i >= 0; i--)
      if (i > int'(index_q) && !mask_q[i]) begin
        last = 1'b0;
        next_index = INDEX_WIDTH'(i);
      end
  end
  always_comb begin
    mask_d = mask_q;
    if (capture) begin
      mask_d[0] = 1'b0;
      for (int i = 1; i < NUM_WAY; i++)
        mask_d[i] = sorted_flatted_in[i*W +: W] == sorted_flatted_in[(i-1)*W +: W];
    end
  end
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) mask_q <= '0;
    else mask_q <= mask_d;
`else
  assign last = index_q == INDEX_WIDTH'(NUM_WAY - 1);
  assign next_index = index_q + 1'b1;
`endif
  always_comb begin
    stream = state_q == STREAM;
    sorted_ready_out = !flush_in && (!stream || (last && element_ready_in));
    capture = sorted_valid_in && sorted_ready_out;
    emit = stream && element_ready_in;
    element_valid_out = stream;
    element_out = stream ? vec_q[index_q] : '0;
    element_index_out = index_q;
    element_last_out = stream && last;
    state_d = state_q;
    index_d = index_q;
    vec_d = vec_q;
    if (flush_in) begin
      state_d = IDLE;
      index_d = '0;
    end else if (capture) begin
      state_d = STREAM;
      index_d = '0;
      for (int i = 0; i < NUM_WAY; i++) vec_d[i] = sorted_flatted_in[i*W +: W];
    end else if (emit) begin
      state_d = last ? IDLE : STREAM;
      index_d = last ? '0 : next_index;
    end
  end
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      state_q <= IDLE;
      index_q <= '0;
      for (int i = 0; i < NUM_WAY; i++) vec_q[i] <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      vec_q <= vec_d;
    end
endmodule
